// File: rtl/qaccel_stream_bridge_if.sv
// Bus bundle between the host-side stream bridge and its environment:
// upstream operand stream, accelerator issue/return lines, downstream
// result stream and bridge status. The master modport is the bridge view,
// the slave modport is the view of whatever surrounds the bridge.
interface qaccel_stream_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                           s_valid;
  logic                           s_ready;
  logic signed [DATA_WIDTH-1:0]   s_a;
  logic signed [DATA_WIDTH-1:0]   s_b;
  logic signed [DATA_WIDTH-1:0]   s_c;
  logic signed [DATA_WIDTH-1:0]   s_d;

  logic                           acc_valid_in;
  logic signed [DATA_WIDTH-1:0]   acc_a;
  logic signed [DATA_WIDTH-1:0]   acc_b;
  logic signed [DATA_WIDTH-1:0]   acc_c;
  logic signed [DATA_WIDTH-1:0]   acc_d;
  logic signed [2*DATA_WIDTH-1:0] acc_q;
  logic                           acc_valid_out;

  logic                           m_valid;
  logic                           m_ready;
  logic signed [2*DATA_WIDTH-1:0] m_q;

  logic [CW-1:0]                  in_flight;
  logic [CW-1:0]                  fifo_level;
  logic                           err_overflow;
  logic                           err_unexpected;

  modport master (
    input  s_valid, s_a, s_b, s_c, s_d,
    input  acc_q, acc_valid_out,
    input  m_ready,
    output s_ready,
    output acc_valid_in, acc_a, acc_b, acc_c, acc_d,
    output m_valid, m_q,
    output in_flight, fifo_level, err_overflow, err_unexpected
  );

  modport slave (
    output s_valid, s_a, s_b, s_c, s_d,
    output acc_q, acc_valid_out,
    output m_ready,
    input  s_ready,
    input  acc_valid_in, acc_a, acc_b, acc_c, acc_d,
    input  m_valid, m_q,
    input  in_flight, fifo_level, err_overflow, err_unexpected
  );
endinterface

// File: rtl/qaccel_stream_bridge.sv
// Ready/valid wrapper around the Q formula accelerator. Operand tuples are
// passed straight through to the accelerator when a credit is available;
// every returning result lands in a first-word-fall-through FIFO that feeds
// the downstream consumer in issue order. A request is only issued when the
// FIFO is guaranteed to have room for its result, so the accelerator (which
// cannot be stalled) never loses data under correct operation.
module qaccel_stream_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  qaccel_stream_bridge_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic signed [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_level;
  logic [CW-1:0] r_inFlight;
  logic          r_errOverflow;
  logic          r_errUnexpected;

  logic [CW:0]   w_credits;
  logic          w_sReady;
  logic          w_issue;
  logic          w_ret;
  logic          w_full;
  logic          w_mValid;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_levelNext;
  logic [CW-1:0] w_inFlightNext;

  // Credits are derived from registered counters only, so s_ready never
  // combinationally depends on s_valid; reset forces it low.
  assign w_credits = {1'b0, r_level} + {1'b0, r_inFlight};
  assign w_sReady  = !reset && (w_credits < {1'b0, DEPTH_C});
  assign w_issue   = bus.s_valid && w_sReady;
  assign w_ret     = bus.acc_valid_out;
  assign w_full    = (r_level == DEPTH_C);
  assign w_mValid  = (r_level != '0);
  assign w_pop     = w_mValid && bus.m_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign w_push    = w_ret && (!w_full || w_pop);

  assign bus.s_ready        = w_sReady;
  assign bus.acc_valid_in   = w_issue;
  assign bus.acc_a          = bus.s_a;
  assign bus.acc_b          = bus.s_b;
  assign bus.acc_c          = bus.s_c;
  assign bus.acc_d          = bus.s_d;
  assign bus.m_valid        = w_mValid;
  assign bus.m_q            = w_mValid ? r_mem[r_rdPtr] : '0;
  assign bus.in_flight      = r_inFlight;
  assign bus.fifo_level     = r_level;
  assign bus.err_overflow   = r_errOverflow;
  assign bus.err_unexpected = r_errUnexpected;

  // Outstanding-request count: issue adds, return subtracts, and a return
  // with nothing outstanding leaves the count pinned at zero.
  always_comb begin
    w_inFlightNext = r_inFlight;
    case ({w_issue, w_ret})
      2'b10:   w_inFlightNext = r_inFlight + 1'b1;
      2'b01:   if (r_inFlight != '0) w_inFlightNext = r_inFlight - 1'b1;
      default: w_inFlightNext = r_inFlight;
    endcase
  end

  // FIFO occupancy follows accepted pushes and pops; both together cancel.
  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop) begin
      w_levelNext = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_levelNext = r_level - 1'b1;
    end
  end

  // Pointers, counters and sticky error flags; pointers wrap naturally
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr         <= '0;
      r_rdPtr         <= '0;
      r_level         <= '0;
      r_inFlight      <= '0;
      r_errOverflow   <= 1'b0;
      r_errUnexpected <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_level    <= w_levelNext;
      r_inFlight <= w_inFlightNext;
      if (w_ret && w_full && !w_pop) r_errOverflow <= 1'b1;
      if (w_ret && (r_inFlight == '0)) r_errUnexpected <= 1'b1;
    end
  end

  // Result storage; contents need no reset because the level gates m_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= bus.acc_q;
  end
endmodule

// File: tb/tb_qaccel_stream_bridge.sv
// Directed bench for the accelerator stream bridge. A small fixed-latency
// behavioural accelerator sits behind the bridge; a direct result injector
// lets the bench force unexpected and overflowing returns.
module tb_qaccel_stream_bridge;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int LAT = 3;

  typedef struct {
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [W-1:0]   c;
    logic signed [W-1:0]   d;
    logic signed [2*W-1:0] q;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qaccel_stream_bridge_if #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  qaccel_stream_bridge #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int invViol  = 0;
  vec_t vecs [4];
  logic signed [2*W-1:0] rxQ [$];

  logic [LAT-1:0]        pv;
  logic signed [2*W-1:0] pq [LAT];
  logic                  injValid;
  logic signed [2*W-1:0] injQ;

  // Behavioural accelerator: Q = ((a-b)*(1+3c) - 4d)/2, floor division
  function automatic logic signed [2*W-1:0] qModel(input logic signed [W-1:0] a, b, c, d);
    logic signed [2*W-1:0] ea, eb, ec, ed, t;
    ea = a; eb = b; ec = c; ed = d;
    t = (ea - eb) * (64'sd1 + 64'sd3 * ec) - 64'sd4 * ed;
    return t >>> 1;
  endfunction

  // Fixed-latency accelerator pipeline sharing the bridge reset
  always @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.acc_valid_in};
      pq[0] <= qModel(bus.acc_a, bus.acc_b, bus.acc_c, bus.acc_d);
      for (int i = 1; i < LAT; i++) pq[i] <= pq[i-1];
    end
  end

  assign bus.acc_valid_out = injValid | pv[LAT-1];
  assign bus.acc_q         = injValid ? injQ : pq[LAT-1];

  // Collect every result handed downstream and watch the credit invariant
  always @(negedge clk) begin
    #2;
    if (!reset && bus.m_valid && bus.m_ready) rxQ.push_back(bus.m_q);
    if (!reset && (int'(bus.fifo_level) + int'(bus.in_flight) > D)) invViol++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic signed [2*W-1:0] rxAt(input int i);
    if (i < rxQ.size()) return rxQ[i];
    return '0;
  endfunction

  // Present one tuple and hold it until accepted; reports cycles spent
  task automatic applyStimulus(input vec_t v, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    bus.s_valid = 1'b1;
    bus.s_a = v.a; bus.s_b = v.b; bus.s_c = v.c; bus.s_d = v.d;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) checkOutput("handshake timeout", 0, 1);
  endtask

  task automatic waitRx(input int n, input string name);
    for (int cyc = 0; cyc < 200 && rxQ.size() < n; cyc++) tick(1);
    checkOutput(name, rxQ.size(), n);
  endtask

  task automatic injectResult(input logic signed [2*W-1:0] q);
    injValid = 1'b1;
    injQ     = q;
    tick(1);
    injValid = 1'b0;
  endtask

  // Stream tuples a=2k,b=0,c=1,d=0 (result 4k) until k passes 'last'
  task automatic streamTuples(input int cycles, input int last, inout int k,
                              inout int issued, inout bit sawReady);
    bit acc;
    for (int cyc = 0; cyc < cycles && k <= last; cyc++) begin
      bus.s_valid = 1'b1;
      bus.s_a = 2 * k; bus.s_b = 0; bus.s_c = 1; bus.s_d = 0;
      @(negedge clk);
      acc = bus.s_ready;
      if (acc) sawReady = 1'b1;
      @(posedge clk);
      #1;
      if (acc) begin
        issued++;
        k++;
      end
    end
    bus.s_valid = (k <= last);
  endtask

  initial begin
    int waited;
    int k;
    int issued;
    bit sawReady;
    bit found;
    vec_t v;

    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a = '0; bus.s_b = '0; bus.s_c = '0; bus.s_d = '0;
    bus.m_ready = 1'b0;
    injValid = 1'b0;
    injQ = '0;

    vecs[0] = '{a: 10, b: 4, c: 2, d: 3, q: 15};
    vecs[1] = '{a: 1,  b: 5, c: 1, d: 0, q: -8};
    vecs[2] = '{a: 3,  b: 0, c: 0, d: 1, q: -1};
    vecs[3] = '{a: 7,  b: 7, c: 9, d: 9, q: -18};

    // Reset behaviour
    tick(3);
    checkOutput("reset s_ready low", bus.s_ready, 0);
    checkOutput("reset m_valid", bus.m_valid, 0);
    reset = 1'b0;
    #1;
    checkOutput("post-reset s_ready", bus.s_ready, 1);
    checkOutput("post-reset in_flight", bus.in_flight, 0);
    checkOutput("post-reset fifo_level", bus.fifo_level, 0);
    checkOutput("post-reset err_overflow", bus.err_overflow, 0);
    checkOutput("post-reset err_unexpected", bus.err_unexpected, 0);
    checkOutput("post-reset m_q", bus.m_q, 0);
    tick(1);

    // Single request then back-to-back requests from the vector table
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], waited);
      if (i == 0) begin
        bus.s_valid = 1'b0;
        checkOutput("t1 in_flight after issue", bus.in_flight, 1);
        waitRx(1, "t1 result count");
        checkOutput("t1 in_flight drained", bus.in_flight, 0);
        checkOutput("t1 fifo_level drained", bus.fifo_level, 0);
      end else begin
        checkOutput("t2 s_ready held", waited, 1);
      end
    end
    bus.s_valid = 1'b0;
    waitRx(4, "t2 result count");
    for (int i = 0; i < 4; i++) checkOutput($sformatf("t1/t2 m_q[%0d]", i), rxAt(i), vecs[i].q);
    tick(5);
    checkOutput("t2 no extra results", rxQ.size(), 4);

    // Backpressure: credits stop issue at FIFO_DEPTH
    rxQ.delete();
    bus.m_ready = 1'b0;
    k = 1; issued = 0; sawReady = 1'b0;
    streamTuples(20, 12, k, issued, sawReady);
    checkOutput("t3 issued under backpressure", issued, 8);
    checkOutput("t3 s_ready low", bus.s_ready, 0);
    checkOutput("t3 fifo_level full", bus.fifo_level, 8);
    checkOutput("t3 in_flight zero", bus.in_flight, 0);
    checkOutput("t3 head m_q", bus.m_q, 4);
    bus.m_ready = 1'b1;
    sawReady = 1'b0;
    streamTuples(60, 12, k, issued, sawReady);
    checkOutput("t3 s_ready reasserted", sawReady, 1);
    checkOutput("t3 total issued", issued, 12);
    waitRx(12, "t3 result count");
    for (int i = 0; i < 12; i++) checkOutput($sformatf("t3 m_q[%0d]", i), rxAt(i), 4 * (i + 1));
    checkOutput("t3 err_overflow", bus.err_overflow, 0);

    // Full FIFO with simultaneous pop and push
    rxQ.delete();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      v = '{a: 2 * i, b: 0, c: 1, d: 0, q: 4 * i};
      applyStimulus(v, waited);
    end
    bus.s_valid = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      @(negedge clk);
      if (bus.acc_valid_out && bus.fifo_level == 7 && bus.in_flight == 1) begin
        found = 1'b1;
        bus.m_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.m_ready = 1'b0;
    end
    checkOutput("t4 reached level 7 with return", found, 1);
    checkOutput("t4 fifo_level kept", bus.fifo_level, 7);
    checkOutput("t4 in_flight", bus.in_flight, 0);
    checkOutput("t4 err_overflow", bus.err_overflow, 0);
    bus.m_ready = 1'b1;
    waitRx(8, "t4 result count");
    for (int i = 0; i < 8; i++) checkOutput($sformatf("t4 m_q[%0d]", i), rxAt(i), 4 * (i + 1));

    // Unexpected return, then overflow
    rxQ.delete();
    bus.m_ready = 1'b0;
    injectResult(64'sh1234);
    checkOutput("t5 err_unexpected", bus.err_unexpected, 1);
    checkOutput("t5 in_flight saturated", bus.in_flight, 0);
    checkOutput("t5 fifo_level", bus.fifo_level, 1);
    checkOutput("t5 m_q", bus.m_q, 64'sh1234);
    for (int i = 0; i < 7; i++) injectResult(64'sh100 + i);
    checkOutput("t5 full no overflow yet", bus.err_overflow, 0);
    injectResult(64'shDEAD);
    checkOutput("t5 err_overflow", bus.err_overflow, 1);
    checkOutput("t5 fifo_level full", bus.fifo_level, 8);
    bus.m_ready = 1'b1;
    waitRx(8, "t5 result count");
    tick(5);
    checkOutput("t5 dropped result absent", rxQ.size(), 8);
    checkOutput("t5 first m_q", rxAt(0), 64'sh1234);
    checkOutput("t5 last m_q", rxAt(7), 64'sh106);
    checkOutput("t5 err_overflow sticky", bus.err_overflow, 1);
    checkOutput("t5 err_unexpected sticky", bus.err_unexpected, 1);

    // Mid-operation reset
    rxQ.delete();
    bus.m_ready = 1'b0;
    applyStimulus(vecs[0], waited);
    applyStimulus(vecs[1], waited);
    bus.s_valid = 1'b0;
    tick(6);
    for (int i = 1; i < 4; i++) applyStimulus(vecs[i], waited);
    checkOutput("t6 in_flight before reset", bus.in_flight, 3);
    checkOutput("t6 fifo_level before reset", bus.fifo_level, 2);
    reset = 1'b1;
    #1;
    checkOutput("t6 s_ready in reset", bus.s_ready, 0);
    checkOutput("t6 acc_valid_in in reset", bus.acc_valid_in, 0);
    tick(1);
    bus.s_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("t6 m_valid", bus.m_valid, 0);
    checkOutput("t6 in_flight", bus.in_flight, 0);
    checkOutput("t6 fifo_level", bus.fifo_level, 0);
    checkOutput("t6 err_overflow", bus.err_overflow, 0);
    checkOutput("t6 err_unexpected", bus.err_unexpected, 0);
    checkOutput("t6 s_ready", bus.s_ready, 1);
    tick(1);
    bus.m_ready = 1'b1;
    applyStimulus(vecs[0], waited);
    bus.s_valid = 1'b0;
    waitRx(1, "t6 result count");
    checkOutput("t6 m_q", rxAt(0), 15);
    tick(8);
    checkOutput("t6 no stale results", rxQ.size(), 1);

    checkOutput("credit invariant violations", invViol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
